// File: rtl/fetch_pipe_ctrl.sv
// Fetch-side pipeline control: owns the PC and the IF/ID register, applies
// redirect / load-use stall / IF flush, and keeps stall/flush statistics.
//
// state | meaning
// ------+----------------------------------------------------
// RUN   | fetching sequentially (normal or explicit flush)
// HOLD  | load-use stall, PC and IF/ID frozen
// REDIR | branch redirect taken, IF/ID holds a bubble
module fetch_pipe_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_STALL = 8,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             if_flush_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             stall_err_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    localparam logic [7:0] MAX_STALL_L = 8'(MAX_STALL);

    state_t      state_q, state_d;
    logic [7:0]  consec_q;
    logic [31:0] pc_plus4;
    logic        do_redir, do_stall, do_flush;

    // Priority decode: redirect beats stall beats flush.
    assign do_redir = branch_taken_i;
    assign do_stall = stall_i & ~branch_taken_i;
    assign do_flush = if_flush_i & ~stall_i & ~branch_taken_i;
    assign pc_plus4 = pc_o + 32'd4;
    assign state_o  = state_q;

    always_comb begin
        state_d = ST_RUN;
        if (do_redir)
            state_d = ST_REDIR;
        else if (do_stall)
            state_d = ST_HOLD;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_o         <= RESET_PC;
            ifid_pc4_o   <= 32'd0;
            ifid_instr_o <= 32'd0;
            ifid_valid_o <= 1'b0;
        end else if (do_redir) begin
            pc_o         <= branch_target_i;
            ifid_pc4_o   <= 32'd0;
            ifid_instr_o <= 32'd0;
            ifid_valid_o <= 1'b0;
        end else if (do_stall) begin
            pc_o         <= pc_o;
        end else if (do_flush) begin
            pc_o         <= pc_plus4;
            ifid_pc4_o   <= 32'd0;
            ifid_instr_o <= 32'd0;
            ifid_valid_o <= 1'b0;
        end else begin
            pc_o         <= pc_plus4;
            ifid_pc4_o   <= pc_plus4;
            ifid_instr_o <= instr_i;
            ifid_valid_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (do_stall && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if ((do_redir || do_flush) && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

    // Watchdog: a redirect edge also breaks the consecutive-stall run.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            consec_q    <= 8'd0;
            stall_err_o <= 1'b0;
        end else if (do_stall) begin
            if (consec_q != MAX_STALL_L)
                consec_q <= consec_q + 8'd1;
            if (consec_q >= MAX_STALL_L - 8'd1)
                stall_err_o <= 1'b1;
        end else begin
            consec_q <= 8'd0;
        end
    end

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl: sequential fetch, stall, redirect,
// flush, watchdog, PC wrap, counter saturation and asynchronous reset.
module tb_fetch_pipe_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, if_flush_i, branch_taken_i;
    logic [31:0] branch_target_i, instr_i;
    logic [31:0] pc_o, ifid_pc4_o, ifid_instr_o;
    logic        ifid_valid_o, stall_err_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    assign instr_i = instr_of(pc_o);

    fetch_pipe_ctrl #(
        .RESET_PC (32'h0000_0000),
        .MAX_STALL(3),
        .CNT_W    (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .if_flush_i     (if_flush_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .instr_i        (instr_i),
        .pc_o           (pc_o),
        .ifid_pc4_o     (ifid_pc4_o),
        .ifid_instr_o   (ifid_instr_o),
        .ifid_valid_o   (ifid_valid_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .stall_err_o    (stall_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check({tag, "_instr"}, ifid_instr_o, instr);
        check({tag, "_pc4"},   ifid_pc4_o,   pc4);
        check({tag, "_valid"}, {31'd0, ifid_valid_o}, {31'd0, valid});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},    pc_o, 32'h0);
        check_ifid(tag, 32'h0, 32'h0, 1'b0);
        check({tag, "_state"}, {30'd0, state_o}, 32'd0);
        check({tag, "_scnt"},  {16'd0, stall_cnt_o}, 32'd0);
        check({tag, "_fcnt"},  {16'd0, flush_cnt_o}, 32'd0);
        check({tag, "_err"},   {31'd0, stall_err_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b0; stall_i = 1'b0; if_flush_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = 32'h0;
        #12;
        check_reset_outputs("reset");
        rst_i = 1'b1;

        // sequential fetch
        step();
        check("seq1_pc", pc_o, 32'h4);
        check_ifid("seq1", instr_of(32'h0), 32'h4, 1'b1);
        step();
        check("seq2_pc", pc_o, 32'h8);
        check_ifid("seq2", instr_of(32'h4), 32'h8, 1'b1);
        check("seq2_scnt", {16'd0, stall_cnt_o}, 32'd0);

        // two-cycle load-use stall at pc 8
        stall_i = 1'b1;
        step();
        check("st1_pc", pc_o, 32'h8);
        check_ifid("st1", instr_of(32'h4), 32'h8, 1'b1);
        check("st1_state", {30'd0, state_o}, 32'd1);
        step();
        check("st2_pc", pc_o, 32'h8);
        check_ifid("st2", instr_of(32'h4), 32'h8, 1'b1);
        check("st2_scnt", {16'd0, stall_cnt_o}, 32'd2);
        stall_i = 1'b0;
        step();
        check("rel_pc", pc_o, 32'hC);
        check_ifid("rel", instr_of(32'h8), 32'hC, 1'b1);
        check("rel_state", {30'd0, state_o}, 32'd0);
        check("rel_err", {31'd0, stall_err_o}, 32'd0);
        step();
        check("seq3_pc", pc_o, 32'h10);

        // redirect with coincident stall and flush
        branch_taken_i = 1'b1; stall_i = 1'b1; if_flush_i = 1'b1;
        branch_target_i = 32'h40;
        step();
        check("redir_pc", pc_o, 32'h40);
        check_ifid("redir", 32'h0, 32'h0, 1'b0);
        check("redir_fcnt", {16'd0, flush_cnt_o}, 32'd1);
        check("redir_scnt", {16'd0, stall_cnt_o}, 32'd2);
        check("redir_state", {30'd0, state_o}, 32'd2);
        branch_taken_i = 1'b0; stall_i = 1'b0; if_flush_i = 1'b0;
        step();
        check("post_redir_pc", pc_o, 32'h44);
        check_ifid("post_redir", instr_of(32'h40), 32'h44, 1'b1);
        check("post_redir_state", {30'd0, state_o}, 32'd0);

        // explicit flush
        if_flush_i = 1'b1;
        step();
        check("flush_pc", pc_o, 32'h48);
        check_ifid("flush", 32'h0, 32'h0, 1'b0);
        check("flush_fcnt", {16'd0, flush_cnt_o}, 32'd2);

        // stall beats flush; flush neither applied nor counted
        stall_i = 1'b1;
        step();
        check("sf_pc", pc_o, 32'h48);
        check("sf_fcnt", {16'd0, flush_cnt_o}, 32'd2);
        check("sf_scnt", {16'd0, stall_cnt_o}, 32'd3);
        stall_i = 1'b0; if_flush_i = 1'b0;
        step();
        check("sf_rel_pc", pc_o, 32'h4C);
        check_ifid("sf_rel", instr_of(32'h48), 32'h4C, 1'b1);

        // watchdog, MAX_STALL = 3
        stall_i = 1'b1;
        step();
        check("wd1_err", {31'd0, stall_err_o}, 32'd0);
        step();
        check("wd2_err", {31'd0, stall_err_o}, 32'd0);
        step();
        check("wd3_err", {31'd0, stall_err_o}, 32'd1);
        step();
        step();
        check("wd5_scnt", {16'd0, stall_cnt_o}, 32'd8);
        stall_i = 1'b0;
        step();
        check("wd_rel_err", {31'd0, stall_err_o}, 32'd1);
        check("wd_rel_pc", pc_o, 32'h50);

        // PC wrap
        branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        step();
        check("wrap_tgt_pc", pc_o, 32'hFFFF_FFFC);
        branch_taken_i = 1'b0;
        step();
        check("wrap_pc", pc_o, 32'h0);
        check_ifid("wrap", instr_of(32'hFFFF_FFFC), 32'h0, 1'b1);

        // stall counter saturation (currently 8)
        stall_i = 1'b1;
        repeat (65526) @(posedge clk_i);
        #1;
        check("sat_below", {16'd0, stall_cnt_o}, 32'hFFFE);
        step();
        check("sat_reach", {16'd0, stall_cnt_o}, 32'hFFFF);
        repeat (5) step();
        check("sat_hold", {16'd0, stall_cnt_o}, 32'hFFFF);

        // asynchronous reset mid-stall, between edges
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #2;
        stall_i = 1'b0;
        rst_i = 1'b1;
        step();
        check("post_rst_pc", pc_o, 32'h4);
        check_ifid("post_rst", instr_of(32'h0), 32'h4, 1'b1);
        check("post_rst_state", {30'd0, state_o}, 32'd0);
        check("post_rst_scnt", {16'd0, stall_cnt_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
